jtframe_rom_2slot_rq: RTL and testbench
=======================================

// Module: jtframe_rom_2slot_rq
// PURPOSE
//   Game-side requester for the SDRAM ROM read port (sdram_req/sdram_ack/sdram_addr/data_read/data_rdy).
//   Serves two independent 16-bit ROM read slots (e.g. CPU and GFX), each backed by a one-line 32-bit cache.
//   Misses are arbitrated round-robin into single SDRAM fetches. Sits in the game module, in the clk_rom domain.
// PARAMETERS
//   SLOT0_AW      13        slot0 address width, in 16-bit words
//   SLOT1_AW      15        slot1 address width, in 16-bit words
//   SLOT0_OFFSET  22'h00000 SDRAM word base of slot0 region
//   SLOT1_OFFSET  22'h10000 SDRAM word base of slot1 region
// PORTS
//   clk_rom      in   1         single clock for all logic
//   rst_n        in   1         reset: synchronous, active-low
//   downloading  in   1         ROM download in progress; invalidates caches, blocks requests
//   loop_rst     in   1         SDRAM controller in init; blocks new requests
//   slot0_cs     in   1         slot0 read request
//   slot0_addr   in   SLOT0_AW  slot0 word address
//   slot0_dout   out  16        slot0 read data
//   slot0_ok     out  1         slot0_dout valid for the current slot0_addr
//   slot1_cs/slot1_addr/slot1_dout/slot1_ok  same as slot0, using SLOT1_AW
//   sdram_req    out  1         fetch request; held high until sdram_ack
//   sdram_ack    in   1         1-cycle pulse: controller has latched sdram_addr
//   sdram_addr   out  22        SDRAM 16-bit-word address, always even
//   data_read    in   32        fetched word: [15:0]=even address, [31:16]=odd address
//   data_rdy     in   1         1-cycle pulse: data_read valid
// BEHAVIOUR
// - Reset (rst_n=0 at a clk_rom edge):
//   - Next cycle: state=IDLE, sdram_req=0, sdram_addr=0, both valid bits=0, line data=0, last_served=1.
//   - slotN_ok=0 and slotN_dout=0 until a fill completes.
// - Per-slot cache state: tag = addr[AW-1:1], 32-bit line, valid bit.
//   - hitN = slotN_cs & validN & (tagN == slotN_addr[AW-1:1]). Combinational.
//   - slotN_ok = hitN. slotN_dout = slotN_addr[0] ? line[31:16] : line[15:0]. Combinational.
//   - A hit therefore costs zero latency.
// - FSM: IDLE -> REQ -> WAIT -> IDLE.
//   - IDLE: missN = slotN_cs & ~hitN. If downloading or loop_rst, no grant.
//     - Only one slot missing: grant it.
//     - Both missing: grant the slot != last_served.
//     - On grant: latch slot id and tag; sdram_addr <= OFFSET + {addr[AW-1:1],1'b0}, zero-extended, mod 2^22 (wraps); sdram_req <= 1; -> REQ.
//   - REQ: hold sdram_req and sdram_addr stable. On sdram_ack: sdram_req <= 0 (low the next cycle); -> WAIT.
//     A data_rdy arriving in REQ is ignored.
//   - WAIT: on data_rdy, the granted slot takes line <= data_read, tag <= latched tag, valid <= 1. last_served <= granted id. -> IDLE.
//     ok is visible from the next cycle, provided the address still matches the tag.
// - Minimum miss latency, cs to ok: 1 (grant) + ack delay + data delay + 1 cycle.
// - Slot address changes during a fetch: the fetch still completes and fills the old tag. The new address then misses in IDLE.
// - An address change only at bit0 never causes a new fetch: both halves of the word are cached.
// - downloading=1 (any state):
//   - Next cycle: sdram_req=0, state=IDLE, both valid=0.
//   - data_rdy is ignored while downloading=1, and any in-flight fill is dropped.
// - loop_rst=1: no new grant from IDLE. An already-issued REQ/WAIT completes normally.
// - Reset during REQ or WAIT: abandons the transfer; any later data_rdy pulse is ignored (state IDLE).
// - sdram_ack seen in IDLE or WAIT: ignored.
// TESTING
// 1. slot0 miss and same-word hit:
//    - Stimulus: after reset, slot0_cs=1, slot0_addr=13'h0005.
//    - sdram_req=1 with sdram_addr=22'h000004. Ack 2 cycles later; data_rdy with 32'hBEEF_1234 3 cycles after that.
//    - Next cycle: slot0_ok=1, dout=16'hBEEF.
//    - Then addr=13'h0004: ok=1 the same cycle, dout=16'h1234, no new sdram_req.
// 2. Round-robin: both slots miss in the same cycle after reset.
//    - Slot0 is served first (sdram_addr=22'h000000), then slot1 (22'h010000 for addr 0).
//    - Both miss again: slot0 and slot1 served alternately.
// 3. Abort on download: assert downloading while in WAIT.
//    - Next cycle: sdram_req=0, both ok=0.
//    - A data_rdy arriving 2 cycles later does not set valid.
//    - After downloading=0, a fresh request is issued.
// 4. Reset mid-REQ: rst_n=0 while sdram_req=1.
//    - Next cycle: sdram_req=0, sdram_addr=0, ok=0.
//    - A stray data_rdy after release of rst_n has no effect.
// 5. Address wrap: SLOT1_OFFSET=22'h3FFFFE, slot1_addr=15'h0002.
//    - sdram_addr=22'h000000.
// 6. Protocol robustness:
//    - data_rdy pulsed in REQ before sdram_ack: ignored, req stays high.
//    - loop_rst=1 in IDLE with a pending miss: no sdram_req until loop_rst=0.

Source files
------------

// File: rtl/jtframe_rom_2slot_rq.sv
// Two-slot ROM read requester: each slot has a one-line 32-bit cache, and misses become single SDRAM fetches granted round-robin.
// Latency: a hit is combinational (0 cycles); a miss takes 1 grant cycle + ack delay + data delay + 1 cycle.
// Backpressure: sdram_req is held with a stable address until sdram_ack; a slot keeps slotN_ok low until its line is filled.
// Ports: clk_rom/rst_n (sync, active-low); downloading/loop_rst gate requests;
//        slotN_cs/slotN_addr -> slotN_dout/slotN_ok per slot;
//        sdram_req/sdram_ack/sdram_addr/data_read/data_rdy SDRAM read port.
module jtframe_rom_2slot_rq #(
  parameter int          SLOT0_AW     = 13,
  parameter int          SLOT1_AW     = 15,
  parameter logic [21:0] SLOT0_OFFSET = 22'h00000,
  parameter logic [21:0] SLOT1_OFFSET = 22'h10000
)(
  input  logic                clk_rom,
  input  logic                rst_n,
  input  logic                downloading,
  input  logic                loop_rst,
  input  logic                slot0_cs,
  input  logic [SLOT0_AW-1:0] slot0_addr,
  output logic [15:0]         slot0_dout,
  output logic                slot0_ok,
  input  logic                slot1_cs,
  input  logic [SLOT1_AW-1:0] slot1_addr,
  output logic [15:0]         slot1_dout,
  output logic                slot1_ok,
  output logic                sdram_req,
  input  logic                sdram_ack,
  output logic [21:0]         sdram_addr,
  input  logic [31:0]         data_read,
  input  logic                data_rdy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]          state;
  logic                valid0, valid1;
  logic [31:0]         line0, line1;
  logic [SLOT0_AW-2:0] tag0, pend_tag0;
  logic [SLOT1_AW-2:0] tag1, pend_tag1;
  logic                last_served;
  logic                gnt_id;

  logic                hit0, hit1, miss0, miss1;
  logic                grant, grant_id;
  logic [21:0]         addr0_ev, addr1_ev;

  // Tag is the 32-bit word address; bit0 only selects the half, so it never causes a fetch.
  assign hit0       = slot0_cs & valid0 & (tag0 == slot0_addr[SLOT0_AW-1:1]);
  assign hit1       = slot1_cs & valid1 & (tag1 == slot1_addr[SLOT1_AW-1:1]);
  assign slot0_ok   = hit0;
  assign slot1_ok   = hit1;
  assign slot0_dout = slot0_addr[0] ? line0[31:16] : line0[15:0];
  assign slot1_dout = slot1_addr[0] ? line1[31:16] : line1[15:0];
  assign miss0      = slot0_cs & ~hit0;
  assign miss1      = slot1_cs & ~hit1;

  // Even SDRAM word address; the 22-bit sum wraps naturally.
  assign addr0_ev = SLOT0_OFFSET + 22'({slot0_addr[SLOT0_AW-1:1], 1'b0});
  assign addr1_ev = SLOT1_OFFSET + 22'({slot1_addr[SLOT1_AW-1:1], 1'b0});

  // Round-robin: on a double miss, the slot not served last wins.
  always_comb begin
    grant    = 1'b0;
    grant_id = 1'b0;
    if (!downloading && !loop_rst) begin
      if (miss0 && miss1) begin
        grant    = 1'b1;
        grant_id = ~last_served;
      end else if (miss0) begin
        grant    = 1'b1;
      end else if (miss1) begin
        grant    = 1'b1;
        grant_id = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_rom) begin
    if (!rst_n) begin
      state       <= IDLE;
      sdram_req   <= 1'b0;
      sdram_addr  <= '0;
      valid0      <= 1'b0;
      valid1      <= 1'b0;
      line0       <= '0;
      line1       <= '0;
      tag0        <= '0;
      tag1        <= '0;
      pend_tag0   <= '0;
      pend_tag1   <= '0;
      last_served <= 1'b1;
      gnt_id      <= 1'b0;
    end else if (downloading) begin
      // ROM contents are changing: drop everything, including any fill in flight.
      state     <= IDLE;
      sdram_req <= 1'b0;
      valid0    <= 1'b0;
      valid1    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            gnt_id    <= grant_id;
            sdram_req <= 1'b1;
            state     <= REQ;
            if (grant_id) begin
              pend_tag1  <= slot1_addr[SLOT1_AW-1:1];
              sdram_addr <= addr1_ev;
            end else begin
              pend_tag0  <= slot0_addr[SLOT0_AW-1:1];
              sdram_addr <= addr0_ev;
            end
          end
        end
        REQ: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // Fill the tag captured at grant time, even if the slot has moved on.
          if (data_rdy) begin
            if (gnt_id) begin
              line1  <= data_read;
              tag1   <= pend_tag1;
              valid1 <= 1'b1;
            end else begin
              line0  <= data_read;
              tag0   <= pend_tag0;
              valid0 <= 1'b1;
            end
            last_served <= gnt_id;
            state       <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          sdram_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_rom_2slot_rq.sv
module tb_jtframe_rom_2slot_rq;

  logic        clk_rom = 1'b0;
  logic        rst_n;
  logic        downloading;
  logic        loop_rst;
  logic        slot0_cs;
  logic [12:0] slot0_addr;
  logic [15:0] slot0_dout;
  logic        slot0_ok;
  logic        slot1_cs;
  logic [14:0] slot1_addr;
  logic [15:0] slot1_dout;
  logic        slot1_ok;
  logic        sdram_req;
  logic        sdram_ack;
  logic [21:0] sdram_addr;
  logic [31:0] data_read;
  logic        data_rdy;

  // Second instance with a wrapping slot1 offset, driven by the same inputs.
  logic [15:0] w_slot0_dout, w_slot1_dout;
  logic        w_slot0_ok, w_slot1_ok, w_req;
  logic [21:0] w_addr;

  int total = 0;
  int bad   = 0;
  logic [21:0] exp_q[$];

  always #5 clk_rom = ~clk_rom;

  jtframe_rom_2slot_rq dut (
    .clk_rom(clk_rom), .rst_n(rst_n), .downloading(downloading), .loop_rst(loop_rst),
    .slot0_cs(slot0_cs), .slot0_addr(slot0_addr), .slot0_dout(slot0_dout), .slot0_ok(slot0_ok),
    .slot1_cs(slot1_cs), .slot1_addr(slot1_addr), .slot1_dout(slot1_dout), .slot1_ok(slot1_ok),
    .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_addr(sdram_addr),
    .data_read(data_read), .data_rdy(data_rdy)
  );

  jtframe_rom_2slot_rq #(.SLOT1_OFFSET(22'h3FFFFE)) dut_w (
    .clk_rom(clk_rom), .rst_n(rst_n), .downloading(downloading), .loop_rst(loop_rst),
    .slot0_cs(slot0_cs), .slot0_addr(slot0_addr), .slot0_dout(w_slot0_dout), .slot0_ok(w_slot0_ok),
    .slot1_cs(slot1_cs), .slot1_addr(slot1_addr), .slot1_dout(w_slot1_dout), .slot1_ok(w_slot1_ok),
    .sdram_req(w_req), .sdram_ack(sdram_ack), .sdram_addr(w_addr),
    .data_read(data_read), .data_rdy(data_rdy)
  );

  task automatic tick;
    @(negedge clk_rom);
  endtask

  task automatic do_reset;
    slot0_cs = 1'b0; slot1_cs = 1'b0; downloading = 1'b0; loop_rst = 1'b0;
    sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
    rst_n = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    tick;
    exp_q.delete();
  endtask

  // SDRAM responder: waits for a request, checks it against the scoreboard,
  // acks after ack_dly cycles and returns data dat_dly cycles after the ack.
  task automatic serve(input int ack_dly, input int dat_dly, input logic [31:0] d);
    int n;
    logic [21:0] e;
    n = 0;
    while (sdram_req !== 1'b1 && n < 50) begin tick; n++; end
    total++;
    if (sdram_req !== 1'b1) begin
      bad++; $display("FAIL req_timeout got=%b exp=1", sdram_req);
      return;
    end
    total++;
    if (exp_q.size() == 0) begin
      bad++; $display("FAIL unexpected_req addr=%h", sdram_addr);
      e = sdram_addr;
    end else begin
      e = exp_q.pop_front();
      if (sdram_addr !== e) begin bad++; $display("FAIL req_addr got=%h exp=%h", sdram_addr, e); end
    end
    repeat (ack_dly) tick;
    total++;
    if (sdram_req !== 1'b1 || sdram_addr !== e) begin
      bad++; $display("FAIL req_hold got=%b/%h exp=1/%h", sdram_req, sdram_addr, e);
    end
    sdram_ack = 1'b1; tick; sdram_ack = 1'b0;
    total++;
    if (sdram_req !== 1'b0) begin bad++; $display("FAIL req_drop got=%b exp=0", sdram_req); end
    repeat (dat_dly - 1) tick;
    data_read = d; data_rdy = 1'b1; tick; data_rdy = 1'b0;
  endtask

  task automatic test_reset;
    slot0_cs = 1'b1; slot0_addr = 13'h0003; slot1_cs = 1'b1; slot1_addr = 15'h0001;
    downloading = 1'b0; loop_rst = 1'b0; sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
    rst_n = 1'b0;
    tick; tick;
    total++;
    if (sdram_req !== 1'b0 || sdram_addr !== 22'h0) begin
      bad++; $display("FAIL reset_req got=%b/%h exp=0/000000", sdram_req, sdram_addr);
    end
    total++;
    if (slot0_ok !== 1'b0 || slot1_ok !== 1'b0 || slot0_dout !== 16'h0 || slot1_dout !== 16'h0) begin
      bad++; $display("FAIL reset_slots got=%b%b/%h/%h exp=00/0000/0000", slot0_ok, slot1_ok, slot0_dout, slot1_dout);
    end
    slot0_cs = 1'b0; slot1_cs = 1'b0;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_miss_hit;
    do_reset;
    slot0_cs = 1'b1; slot0_addr = 13'h0005;
    exp_q.push_back(22'h000004);
    serve(2, 3, 32'hBEEF_1234);
    total++;
    if (slot0_ok !== 1'b1 || slot0_dout !== 16'hBEEF) begin
      bad++; $display("FAIL miss_fill got=%b/%h exp=1/beef", slot0_ok, slot0_dout);
    end
    slot0_addr = 13'h0004;
    #1;
    total++;
    if (slot0_ok !== 1'b1 || slot0_dout !== 16'h1234) begin
      bad++; $display("FAIL same_word_hit got=%b/%h exp=1/1234", slot0_ok, slot0_dout);
    end
    tick; tick;
    total++;
    if (sdram_req !== 1'b0) begin bad++; $display("FAIL no_refetch got=%b exp=0", sdram_req); end
  endtask

  task automatic test_round_robin;
    do_reset;
    slot0_cs = 1'b1; slot0_addr = 13'h0000; slot1_cs = 1'b1; slot1_addr = 15'h0000;
    exp_q.push_back(22'h000000); exp_q.push_back(22'h010000);
    serve(1, 1, 32'hA0A1_A0A0);
    total++;
    if (slot0_ok !== 1'b1 || slot0_dout !== 16'hA0A0 || slot1_ok !== 1'b0) begin
      bad++; $display("FAIL rr_first got=%b/%h/%b exp=1/a0a0/0", slot0_ok, slot0_dout, slot1_ok);
    end
    serve(1, 1, 32'hB1B1_B0B0);
    total++;
    if (slot1_ok !== 1'b1 || slot1_dout !== 16'hB0B0 || slot0_ok !== 1'b1) begin
      bad++; $display("FAIL rr_second got=%b/%h/%b exp=1/b0b0/1", slot1_ok, slot1_dout, slot0_ok);
    end
    // Both miss again after slot1 was served last: slot0 first.
    slot0_addr = 13'h0002; slot1_addr = 15'h0003;
    exp_q.push_back(22'h000002); exp_q.push_back(22'h010002);
    serve(0, 2, 32'hC0C1_C0C0);
    serve(1, 1, 32'hD1D1_D0D0);
    total++;
    if (slot0_dout !== 16'hC0C0 || slot1_dout !== 16'hD1D1 || !slot0_ok || !slot1_ok) begin
      bad++; $display("FAIL rr_round2 got=%h/%h exp=c0c0/d1d1", slot0_dout, slot1_dout);
    end
    // Serve slot0 alone, then a double miss must go to slot1 first.
    slot0_addr = 13'h0006;
    exp_q.push_back(22'h000006);
    serve(1, 1, 32'h6666_6060);
    slot0_addr = 13'h0008; slot1_addr = 15'h0008;
    exp_q.push_back(22'h010008); exp_q.push_back(22'h000008);
    serve(1, 1, 32'h1818_1808);
    total++;
    if (slot1_ok !== 1'b1 || slot0_ok !== 1'b0 || slot1_dout !== 16'h1808) begin
      bad++; $display("FAIL rr_slot1_first got=%b%b/%h exp=10/1808", slot1_ok, slot0_ok, slot1_dout);
    end
    serve(1, 1, 32'h0808_0800);
    total++;
    if (slot0_ok !== 1'b1 || slot0_dout !== 16'h0800) begin
      bad++; $display("FAIL rr_slot0_after got=%b/%h exp=1/0800", slot0_ok, slot0_dout);
    end
  endtask

  task automatic test_download_abort;
    do_reset;
    slot0_cs = 1'b1; slot0_addr = 13'h0010;
    tick;
    total++;
    if (sdram_req !== 1'b1 || sdram_addr !== 22'h000010) begin
      bad++; $display("FAIL dl_req got=%b/%h exp=1/000010", sdram_req, sdram_addr);
    end
    sdram_ack = 1'b1; tick; sdram_ack = 1'b0;
    downloading = 1'b1;
    tick;
    total++;
    if (sdram_req !== 1'b0 || slot0_ok !== 1'b0 || slot1_ok !== 1'b0) begin
      bad++; $display("FAIL dl_abort got=%b/%b%b exp=0/00", sdram_req, slot0_ok, slot1_ok);
    end
    tick;
    data_read = 32'hDEAD_DEAD; data_rdy = 1'b1; tick; data_rdy = 1'b0;
    downloading = 1'b0;
    total++;
    if (slot0_ok !== 1'b0) begin bad++; $display("FAIL dl_drop got=%b exp=0", slot0_ok); end
    exp_q.push_back(22'h000010);
    serve(1, 1, 32'h5555_1010);
    total++;
    if (slot0_ok !== 1'b1 || slot0_dout !== 16'h1010) begin
      bad++; $display("FAIL dl_refetch got=%b/%h exp=1/1010", slot0_ok, slot0_dout);
    end
  endtask

  task automatic test_reset_mid_req;
    do_reset;
    slot0_cs = 1'b1; slot0_addr = 13'h0020;
    tick;
    total++;
    if (sdram_req !== 1'b1) begin bad++; $display("FAIL rq_req got=%b exp=1", sdram_req); end
    rst_n = 1'b0; slot0_cs = 1'b0;
    tick;
    total++;
    if (sdram_req !== 1'b0 || sdram_addr !== 22'h0 || slot0_ok !== 1'b0) begin
      bad++; $display("FAIL rq_reset got=%b/%h/%b exp=0/000000/0", sdram_req, sdram_addr, slot0_ok);
    end
    rst_n = 1'b1;
    tick;
    data_read = 32'h2020_2020; data_rdy = 1'b1; tick; data_rdy = 1'b0;
    slot0_cs = 1'b1;
    #1;
    total++;
    if (slot0_ok !== 1'b0 || sdram_req !== 1'b0) begin
      bad++; $display("FAIL rq_stray got=%b/%b exp=0/0", slot0_ok, sdram_req);
    end
    exp_q.push_back(22'h000020);
    serve(1, 1, 32'h3333_4444);
    total++;
    if (slot0_ok !== 1'b1 || slot0_dout !== 16'h4444) begin
      bad++; $display("FAIL rq_after got=%b/%h exp=1/4444", slot0_ok, slot0_dout);
    end
  endtask

  task automatic test_wrap;
    do_reset;
    slot1_cs = 1'b1; slot1_addr = 15'h0002;
    tick;
    total++;
    if (w_req !== 1'b1 || w_addr !== 22'h000000) begin
      bad++; $display("FAIL wrap_addr got=%b/%h exp=1/000000", w_req, w_addr);
    end
    exp_q.push_back(22'h010002);
    serve(1, 1, 32'h7777_8888);
    total++;
    if (w_slot1_ok !== 1'b1 || w_slot1_dout !== 16'h8888) begin
      bad++; $display("FAIL wrap_fill got=%b/%h exp=1/8888", w_slot1_ok, w_slot1_dout);
    end
  endtask

  task automatic test_protocol;
    do_reset;
    slot0_cs = 1'b1; slot0_addr = 13'h0030;
    tick;
    data_read = 32'hBAD0_BAD0; data_rdy = 1'b1; tick; data_rdy = 1'b0;
    total++;
    if (sdram_req !== 1'b1 || sdram_addr !== 22'h000030 || slot0_ok !== 1'b0) begin
      bad++; $display("FAIL early_rdy got=%b/%h/%b exp=1/000030/0", sdram_req, sdram_addr, slot0_ok);
    end
    exp_q.push_back(22'h000030);
    serve(0, 1, 32'h3131_3030);
    total++;
    if (slot0_ok !== 1'b1 || slot0_dout !== 16'h3030) begin
      bad++; $display("FAIL early_rdy_fill got=%b/%h exp=1/3030", slot0_ok, slot0_dout);
    end
    loop_rst = 1'b1; slot0_addr = 13'h0041;
    for (int i = 0; i < 3; i++) begin
      tick;
      total++;
      if (sdram_req !== 1'b0) begin bad++; $display("FAIL loop_rst_block cyc=%0d got=%b exp=0", i, sdram_req); end
    end
    loop_rst = 1'b0;
    exp_q.push_back(22'h000040);
    serve(1, 2, 32'h4141_4040);
    total++;
    if (slot0_ok !== 1'b1 || slot0_dout !== 16'h4141) begin
      bad++; $display("FAIL loop_rst_fill got=%b/%h exp=1/4141", slot0_ok, slot0_dout);
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    rst_n = 1'b0; downloading = 1'b0; loop_rst = 1'b0;
    slot0_cs = 1'b0; slot0_addr = '0; slot1_cs = 1'b0; slot1_addr = '0;
    sdram_ack = 1'b0; data_read = '0; data_rdy = 1'b0;
    tick;
    test_reset;
    test_miss_hit;
    test_round_robin;
    test_download_abort;
    test_reset_mid_req;
    test_wrap;
    test_protocol;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
